// File: rtl/wb_bus_monitor.sv
// Passive monitor for NCH pipelined Wishbone channels: protocol checks,
// per-channel stall/ack watchdog and saturating traffic statistics.
module wb_bus_monitor #(
    parameter  int NCH     = 4,
    parameter  int TIMEOUT = 1024,
    parameter  int MAX_OUT = 8,
    parameter  int CNT_W   = 32,
    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   cyc,
    input  logic [NCH-1:0]   stb,
    input  logic [NCH-1:0]   we,
    input  logic [NCH-1:0]   stall,
    input  logic [NCH-1:0]   ack,
    input  logic [NCH-1:0]   err,
    input  logic             clear,
    input  logic [5:0]       irq_mask,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [6*NCH-1:0] flags,
    output logic             irq
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_WAIT
    } state_e;

    state_e           st_q  [NCH];
    state_e           st_d  [NCH];
    logic [OUT_W-1:0] out_q [NCH];
    logic [OUT_W-1:0] out_d [NCH];
    logic [WD_W-1:0]  wd_q  [NCH];
    logic [WD_W-1:0]  wd_d  [NCH];
    logic [CNT_W-1:0] cnt_q [NCH][4];
    logic [CNT_W-1:0] cnt_d [NCH][4];
    logic [6*NCH-1:0] flags_q;
    logic [6*NCH-1:0] flags_d;
    logic [CNT_W-1:0] rd_q;
    logic [CNT_W-1:0] rd_d;
    logic             irq_q;
    logic             irq_d;
    logic [NCH-1:0]   acc;
    logic [NCH-1:0]   rsp;

    assign acc = cyc & stb & ~stall;
    assign rsp = ack | err;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_comb begin
        flags_d = flags_q;
        for (int c = 0; c < NCH; c++) begin
            out_d[c] = out_q[c];
            wd_d[c]  = '0;
            st_d[c]  = S_IDLE;
            for (int k = 0; k < 4; k++) begin
                cnt_d[c][k] = cnt_q[c][k];
            end

            // a dropped cycle abandons everything still in flight
            if (!cyc[c]) begin
                out_d[c] = '0;
            end else if (acc[c] && !rsp[c] && out_q[c] != OUT_MAX) begin
                out_d[c] = out_q[c] + OUT_W'(1);
            end else if (!acc[c] && rsp[c] && out_q[c] != '0) begin
                out_d[c] = out_q[c] - OUT_W'(1);
            end

            if (st_q[c] == S_WAIT && cyc[c] && !rsp[c]) begin
                wd_d[c] = (wd_q[c] == WD_MAX) ? wd_q[c]
                                              : wd_q[c] + WD_W'(1);
            end

            flags_d[6*c+0] = flags_q[6*c+0] | (stb[c] & ~cyc[c]);
            flags_d[6*c+1] = flags_q[6*c+1]
                           | (rsp[c] & (st_q[c] != S_WAIT) & ~acc[c]);
            flags_d[6*c+2] = flags_q[6*c+2] | (ack[c] & err[c]);
            flags_d[6*c+3] = flags_q[6*c+3]
                           | (~cyc[c] & (st_q[c] == S_WAIT));
            flags_d[6*c+4] = flags_q[6*c+4]
                           | (acc[c] & ~rsp[c] & (out_q[c] == OUT_MAX));
            flags_d[6*c+5] = flags_q[6*c+5]
                           | ((wd_d[c] == WD_MAX) && (wd_q[c] != WD_MAX));

            cnt_d[c][0] = sat_inc(cnt_q[c][0], acc[c] & ~we[c]);
            cnt_d[c][1] = sat_inc(cnt_q[c][1], acc[c] & we[c]);
            cnt_d[c][2] = sat_inc(cnt_q[c][2], ack[c]);
            cnt_d[c][3] = sat_inc(cnt_q[c][3], err[c] & ~ack[c]);

            if (clear) begin
                out_d[c] = '0;
                wd_d[c]  = '0;
                flags_d[6*c +: 6] = '0;
                for (int k = 0; k < 4; k++) begin
                    cnt_d[c][k] = '0;
                end
            end

            if (!cyc[c]) begin
                st_d[c] = S_IDLE;
            end else if (out_d[c] != '0) begin
                st_d[c] = S_WAIT;
            end else begin
                st_d[c] = S_ACTIVE;
            end
        end
    end

    always_comb begin
        rd_d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                rd_d = cnt_q[c][rd_sel];
            end
        end
        if (clear) begin
            rd_d = '0;
        end
    end

    assign irq_d = |(flags_q & {NCH{irq_mask}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            rd_q    <= '0;
            irq_q   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                st_q[c]  <= S_IDLE;
                out_q[c] <= '0;
                wd_q[c]  <= '0;
                for (int k = 0; k < 4; k++) begin
                    cnt_q[c][k] <= '0;
                end
            end
        end else begin
            flags_q <= flags_d;
            rd_q    <= rd_d;
            irq_q   <= irq_d;
            for (int c = 0; c < NCH; c++) begin
                st_q[c]  <= st_d[c];
                out_q[c] <= out_d[c];
                wd_q[c]  <= wd_d[c];
                for (int k = 0; k < 4; k++) begin
                    cnt_q[c][k] <= cnt_d[c][k];
                end
            end
        end
    end

    assign rd_data = rd_q;
    assign flags   = flags_q;
    assign irq     = irq_q;

endmodule
